// File: rtl/lfsr_key_step_if.sv
// ----------------------------------------------------------------------------
// lfsr_key_step_if
//   Groups the button, control and LFSR output signals of lfsr_key_step.
//   master : drives key_n/auto_en/load/seed, observes q/step_pulse
//   slave  : the lfsr_key_step block itself
// Ports (signals):
//   key_n      raw active-low push button, asynchronous to clk
//   auto_en    auto-repeat enable while the button is held
//   load       synchronous seed load strobe
//   seed[7:0]  value loaded on load (zero is replaced by 8'h01)
//   q[7:0]     current LFSR state
//   step_pulse one-cycle flag marking the cycle q took a stepped value
// ----------------------------------------------------------------------------
interface lfsr_key_step_if;
    logic       key_n;
    logic       auto_en;
    logic       load;
    logic [7:0] seed;
    logic [7:0] q;
    logic       step_pulse;

    modport master (
        output key_n, auto_en, load, seed,
        input  q, step_pulse
    );

    modport slave (
        input  key_n, auto_en, load, seed,
        output q, step_pulse
    );
endinterface

// File: rtl/lfsr_key_step.sv
// ----------------------------------------------------------------------------
// lfsr_key_step
//   Debounces a raw active-low push button and advances an 8-bit Fibonacci
//   LFSR (taps 8,6,5,4 -> fb = q[4]^q[3]^q[2]^q[0], shift right) exactly once
//   per accepted press, with optional auto-repeat while held and a
//   synchronous seed load. q drives two hex seven-segment decoders directly.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   lfsr_key_step_if.slave : key_n, auto_en, load, seed in; q, step_pulse out
// Parameters:
//   DEB_CNT  cycles the synchronized key must be stable to accept press/release
//   REP_CNT  cycles between auto-repeat steps while held
//   CNT_W    counter width, must hold max(DEB_CNT, REP_CNT)-1
//   SEED     reset value of q, non-zero
// ----------------------------------------------------------------------------
module lfsr_key_step #(
    parameter int unsigned DEB_CNT = 1000000,
    parameter int unsigned REP_CNT = 25000000,
    parameter int unsigned CNT_W   = 25,
    parameter logic [7:0]  SEED    = 8'h01
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_key_step_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CNT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;        // debounce counter (PRESS_WAIT / RELEASE_WAIT)
    logic [CNT_W-1:0] rep_cnt;    // auto-repeat counter (HELD)
    logic [1:0]       key_sync;   // [0] first flop, [1] second flop; 1 = released
    logic [7:0]       q_r;
    logic             pulse_r;

    logic             pressed;
    logic             deb_done;
    logic             rep_done;
    logic             step_due;
    logic [7:0]       lfsr_next;
    logic [7:0]       seed_fix;

    assign bus.q          = q_r;
    assign bus.step_pulse = pulse_r;

    always_comb begin
        pressed   = ~key_sync[1];
        deb_done  = (cnt == DEB_LAST);
        rep_done  = (rep_cnt == REP_LAST);
        // A step is due either at debounce expiry of a press or when the
        // repeat interval elapses while held with auto-repeat enabled.
        step_due  = pressed &&
                    (((state == PRESS_WAIT) && deb_done) ||
                     ((state == HELD) && bus.auto_en && rep_done));
        lfsr_next = {q_r[4] ^ q_r[3] ^ q_r[2] ^ q_r[0], q_r[7:1]};
        // All-zero is the LFSR lock-up state; never let a load put us there.
        seed_fix  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rep_cnt  <= '0;
            key_sync <= 2'b11;
            q_r      <= SEED;
            pulse_r  <= 1'b0;
        end else begin
            key_sync <= {key_sync[0], bus.key_n};

            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;            // glitch, no step
                    end else if (deb_done) begin
                        state   <= HELD;
                        rep_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state   <= RELEASE_WAIT;
                        cnt     <= '0;
                        rep_cnt <= '0;
                    end else if (bus.auto_en) begin
                        rep_cnt <= rep_done ? '0 : rep_cnt + 1'b1;
                    end else begin
                        rep_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state   <= HELD;          // bounce on release, no step
                        rep_cnt <= '0;
                    end else if (deb_done) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // Load wins over a coincident step; that step is dropped.
            if (bus.load) begin
                q_r     <= seed_fix;
                pulse_r <= 1'b0;
            end else if (step_due) begin
                q_r     <= lfsr_next;
                pulse_r <= 1'b1;
            end else begin
                pulse_r <= 1'b0;
            end
        end
    end

endmodule
